// File: rtl/dmg_capture_ctrl.sv
// Captures DMG LCD pixels into a two-bank ping-pong frame buffer. Only complete
// frames are handed to the VGA reader, and banks swap only at the start of VGA vertical blank.
module dmg_capture_ctrl #(
  parameter int H_PIXELS    = 160,
  parameter int V_LINES     = 144,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK25MHz,
  input  logic                  reset_n,
  input  logic                  lcd_clk,
  input  logic                  lcd_vsync,
  input  logic [DATA_WIDTH-1:0] lcd_data,
  input  logic                  vga_vblank,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_bank,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [7:0]            frame_count
);

  localparam int FRAME_PIX = H_PIXELS * V_LINES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  // Reset asserts immediately but releases on a clock edge, so the core leaves
  // reset on the second rising edge after reset_n goes high.
  logic rst_sync_q;
  logic rst_n;

  always_ff @(posedge CLK25MHz or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;
  end

  assign rst_n = rst_sync_q;

  logic [SYNC_STAGES-1:0] lclk_sync_q;
  logic [SYNC_STAGES-1:0] vs_sync_q;
  logic [DATA_WIDTH-1:0]  data_sync_q [SYNC_STAGES];
  logic                   lclk_hist_q;
  logic                   vs_hist_q;
  logic                   vb_q;

  always_ff @(posedge CLK25MHz or negedge rst_n) begin
    if (!rst_n) begin
      lclk_sync_q <= '0;
      vs_sync_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      lclk_hist_q <= 1'b0;
      vs_hist_q   <= 1'b0;
      vb_q        <= 1'b0;
    end else begin
      lclk_sync_q <= {lclk_sync_q[SYNC_STAGES-2:0], lcd_clk};
      vs_sync_q   <= {vs_sync_q[SYNC_STAGES-2:0], lcd_vsync};
      data_sync_q[0] <= lcd_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
      lclk_hist_q <= lclk_sync_q[SYNC_STAGES-1];
      vs_hist_q   <= vs_sync_q[SYNC_STAGES-1];
      vb_q        <= vga_vblank;
    end
  end

  logic                  lclk_s;
  logic                  vs_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  pix_edge;
  logic                  vs_edge;
  logic                  vb_edge;

  assign lclk_s   = lclk_sync_q[SYNC_STAGES-1];
  assign vs_s     = vs_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign pix_edge = lclk_hist_q & ~lclk_s;
  assign vs_edge  = vs_s & ~vs_hist_q;
  assign vb_edge  = vga_vblank & ~vb_q;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pending_q, pending_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    pending_d     = pending_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_done_d  = 1'b0;
    frame_err_d   = frame_err_q;
    frame_count_d = frame_count_q;

    // Swap looks at the registered pending flag, so a frame completing in this
    // same cycle waits for the next vblank.
    if (vb_edge && pending_q) begin
      wr_bank_d     = ~wr_bank_q;
      rd_bank_d     = wr_bank_q;
      pending_d     = 1'b0;
      frame_count_d = frame_count_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (vs_edge) begin
          state_d = S_CAPTURE;
          addr_d  = '0;
        end
      end
      S_CAPTURE: begin
        if (vs_edge) begin
          if (addr_q != '0) frame_err_d = 1'b1;
          addr_d = '0;
        end else if (pix_edge && !vs_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_s;
          if (addr_q == LAST_ADDR) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
            pending_d    = 1'b1;
            addr_d       = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (vs_edge && !pending_q) begin
          state_d = S_CAPTURE;
          addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      pending_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pending_q     <= pending_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_bank     = wr_bank_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_bank     = rd_bank_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule
